ahb_stream_slave: RTL and testbench
===================================

// Module: ahb_stream_slave
// PURPOSE
//  AHB-Lite slave that sits directly downstream of axi2ahb. It terminates the bridge's
//  AHB master port and exposes a control/status register pair plus a push-only data window.
//  Words written to the data window are buffered in a FIFO and streamed to a compute core
//  over a valid/ready interface. Full FIFO back-pressures AHB through HREADY wait states.
// PARAMETERS
//  ADDR_WIDTH   8    HADDR width, equal to the bridge's AXI_ADDR_WIDTH
//  DATA_WIDTH   32   HWDATA/HRDATA/M_DATA width
//  FIFO_DEPTH   32   data FIFO entries; power of two, 2..128
//  DATA_WADDR   16   word address (HADDR[ADDR_WIDTH-1:2]) of the data window (byte 0x40)
// PORTS
//  ACLK      in   1            clock
//  ARESET    in   1            asynchronous, active-high reset
//  HADDR     in   ADDR_WIDTH   AHB address
//  HBURST    in   3            burst type; informational only
//  HSIZE     in   3            only 3'b010 (word) supported
//  HTRANS    in   2            IDLE/BUSY/NONSEQ/SEQ
//  HWRITE    in   1            1 = write
//  HWDATA    in   DATA_WIDTH   write data, valid in the data phase
//  HREADY    out  1            transfer done / wait-state control back to the bridge
//  HRDATA    out  DATA_WIDTH   read data
//  HRESP     out  1            0 = OKAY, 1 = ERROR
//  START     out  1            one-cycle start pulse to the core
//  M_DATA    out  DATA_WIDTH   FIFO head
//  M_VALID   out  1            FIFO not empty
//  M_READY   in   1            core accepts M_DATA
// BEHAVIOUR
//  Reset values: HREADY=1, HRDATA=0, HRESP=0, START=0, M_VALID=0. FIFO is empty, the
//    address-phase registers are cleared, and the FSM is in IDLE. Reset mid-transfer abandons it.
//  Address phase: HTRANS[1]=1 and HREADY=1 register HADDR word, HWRITE and HSIZE into the data-phase regs.
//    BUSY and IDLE are ignored, with zero wait states.
//  Register map (word address):
//    0  CTRL    W: bit0 START → pulse 1 cycle after the data phase; bit1 CLR → empty FIFO. R: 0
//    1  STATUS  R: {16'b0, level[7:0], 6'b0, full, empty}; writes ignored
//    DATA_WADDR  W: push HWDATA; R: 0
//  Data phase write to DATA with FIFO full: HREADY=0 until a pop frees an entry.
//    The push happens in the cycle HREADY returns to 1. Push and pop in the same cycle at full is allowed.
//  Reads: HRDATA is driven combinationally in the data phase from the latched address. Zero wait states.
//  FIFO: level width $clog2(FIFO_DEPTH)+1. A pop happens when M_VALID && M_READY.
//    Read and write pointers wrap modulo FIFO_DEPTH. Level never exceeds FIFO_DEPTH.
//  CLR and a pop in the same cycle: CLR wins, and M_VALID is 0 the next cycle.
//  A pending stalled push is not possible during a CTRL write, because AHB phases are ordered.
//  FSM: IDLE → ADDR_OK (data phase, no stall) | STALL (DATA write, full) | ERR1 → ERR2 (macro only).
//    STALL → ADDR_OK when !full || pop.
// CONFIGURATION
//  AHB_SLV_ERR_EN defined: the following get a 2-cycle ERROR response (cycle1 HREADY=0 HRESP=1,
//    cycle2 HREADY=1 HRESP=1): unmapped word address, HSIZE != 3'b010, DATA read, and STATUS write.
//    No side effects.
//  Undefined: these accesses complete OKAY with zero wait states. Writes are dropped and reads return 0.
//    HRESP is tied 0.
// STRUCTURE
//  Package ahb_stream_pkg: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HRESP codes,
//    CTRL/STATUS word offsets, CTRL bit indices, FSM state encoding.
//  Sub-module sync_fifo (DATA_WIDTH, FIFO_DEPTH): push/pop/clr, full/empty/level, async active-high reset.
// TESTING
//  1. Write 0x03 to byte 0x00 → START high for exactly 1 cycle, FIFO empty, STATUS read = 0x0000_0001.
//  2. 32-beat fixed burst to 0x40, M_READY=0 → zero wait states. STATUS = 0x0000_2002. M_DATA = first word.
//  3. 33rd write to 0x40 with FIFO full → HREADY=0. Raise M_READY for 1 cycle → HREADY=1 the next cycle,
//     and the word is stored at the tail.
//  4. M_READY=1 continuously during a 32-beat burst → no stalls. Output order matches input order.
//     STATUS ends at 0x0000_0001.
//  5. Assert ARESET during a stalled DATA write → HREADY=1 and M_VALID=0 immediately. The next access is OKAY.
//  6. With AHB_SLV_ERR_EN, write to byte 0x80 → HRESP=1 for 2 cycles with HREADY 0 then 1, and no FIFO change.
//     Without AHB_SLV_ERR_EN → OKAY with no effect.

Source files
------------

// File: rtl/ahb_stream_pkg.sv
// Shared definitions for the AHB stream slave: AHB encodings, register map,
// CTRL bit positions, FSM state encoding and the STATUS word packer.
package ahb_stream_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    // Word offsets of the control/status registers
    localparam int CTRL_WADDR   = 0;
    localparam int STATUS_WADDR = 1;

    // CTRL register bit positions
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CLR_BIT   = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_OK = 3'd1,
        ST_STALL   = 3'd2,
        ST_ERR1    = 3'd3,
        ST_ERR2    = 3'd4
    } state_e;

    // STATUS layout: {16'b0, level[7:0], 6'b0, full, empty}
    function automatic logic [31:0] status_word(input logic [7:0] level,
                                                input logic       full,
                                                input logic       empty);
        return {16'b0, level, 6'b0, full, empty};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear and asynchronous active-high reset.
// Pops are ignored when empty; a push at full is accepted only alongside a pop.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic                          clr_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q, rptr_q;
    logic [LVL_W-1:0]      level_q;
    logic                  do_push, do_pop;

    assign full_o  = (level_q == LVL_MAX);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and level bookkeeping; clear overrides any push/pop in the same cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_ONE;
            if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage array; contents need no reset since level gates visibility
    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ahb_stream_slave.sv
// AHB-Lite slave behind axi2ahb: CTRL/STATUS registers plus a push-only data
// window feeding a FIFO that streams to a core over valid/ready.
// A full FIFO stalls the data-window write with HREADY wait states.
// Optional macro AHB_SLV_ERR_EN: unmapped/illegal accesses get a two-cycle
// ERROR response; without it they complete OKAY with no effect.
module ahb_stream_slave
    import ahb_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32,
    parameter int DATA_WADDR = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [2:0]            HBURST,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HRESP,
    output logic                  START,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  M_VALID,
    input  logic                  M_READY
);
    localparam int WA_W  = ADDR_WIDTH - 2;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WA_W-1:0] CTRL_WA   = WA_W'(CTRL_WADDR);
    localparam logic [WA_W-1:0] STATUS_WA = WA_W'(STATUS_WADDR);
    localparam logic [WA_W-1:0] DATA_WA   = WA_W'(DATA_WADDR);

    state_e          state_q, state_d;
    logic [WA_W-1:0] waddr_q, waddr_d;
    logic            write_q, write_d;
    logic [2:0]      size_q,  size_d;
    logic            start_q, start_d;

    logic             fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
    logic [LVL_W-1:0] fifo_level;

    logic                  hready_c, hresp_c;
    logic [DATA_WIDTH-1:0] hrdata_c;
    logic [WA_W-1:0]       haddr_word;
    logic                  addr_valid, addr_err;
    logic                  size_ok, dp_data_wr, dp_ctrl_wr, dp_status_rd;
    logic                  unused_ok;

    // HBURST is informational and byte-lane bits are irrelevant for word access
    assign unused_ok = ^{HBURST, HADDR[1:0]};

    assign haddr_word = HADDR[ADDR_WIDTH-1:2];
    // Only NONSEQ/SEQ start a transfer; IDLE and BUSY are accepted with no effect
    assign addr_valid = (htrans_e'(HTRANS) == HTRANS_NONSEQ) ||
                        (htrans_e'(HTRANS) == HTRANS_SEQ);

`ifdef AHB_SLV_ERR_EN
    // Classify the incoming address phase as an access that must be refused
    always_comb begin
        addr_err = 1'b0;
        if (HSIZE != HSIZE_WORD)                             addr_err = 1'b1;
        if (haddr_word != CTRL_WA && haddr_word != STATUS_WA &&
            haddr_word != DATA_WA)                           addr_err = 1'b1;
        if (haddr_word == DATA_WA && !HWRITE)                addr_err = 1'b1;
        if (haddr_word == STATUS_WA && HWRITE)               addr_err = 1'b1;
    end
`else
    assign addr_err = 1'b0;
`endif

    // Data-phase decode from the latched address; illegal sizes do nothing
    assign size_ok      = (size_q == HSIZE_WORD);
    assign dp_data_wr   = write_q  && size_ok && (waddr_q == DATA_WA);
    assign dp_ctrl_wr   = write_q  && size_ok && (waddr_q == CTRL_WA);
    assign dp_status_rd = !write_q && size_ok && (waddr_q == STATUS_WA);

    assign fifo_pop = M_READY && !fifo_empty;

    // Next-state, address capture and data-phase outputs
    always_comb begin
        logic take_addr;
        state_d   = state_q;
        waddr_d   = waddr_q;
        write_d   = write_q;
        size_d    = size_q;
        start_d   = 1'b0;
        hready_c  = 1'b1;
        hresp_c   = HRESP_OKAY;
        hrdata_c  = '0;
        fifo_push = 1'b0;
        fifo_clr  = 1'b0;
        take_addr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                take_addr = 1'b1;
            end
            ST_ADDR_OK: begin
                // A full FIFO stalls the push unless a pop frees a slot this cycle
                if (dp_data_wr && fifo_full && !fifo_pop) begin
                    hready_c = 1'b0;
                    state_d  = ST_STALL;
                end else begin
                    fifo_push = dp_data_wr;
                    fifo_clr  = dp_ctrl_wr && HWDATA[CTRL_CLR_BIT];
                    start_d   = dp_ctrl_wr && HWDATA[CTRL_START_BIT];
                    if (dp_status_rd)
                        hrdata_c = DATA_WIDTH'(status_word(8'(fifo_level), fifo_full, fifo_empty));
                    take_addr = 1'b1;
                end
            end
            ST_STALL: begin
                // Hold the bus; the push completes in ADDR_OK once a slot is free
                hready_c = 1'b0;
                if (!fifo_full || fifo_pop) state_d = ST_ADDR_OK;
            end
`ifdef AHB_SLV_ERR_EN
            ST_ERR1: begin
                hready_c = 1'b0;
                hresp_c  = HRESP_ERROR;
                state_d  = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_c   = HRESP_ERROR;
                take_addr = 1'b1;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_addr) begin
            if (addr_valid) begin
                waddr_d = haddr_word;
                write_d = HWRITE;
                size_d  = HSIZE;
                state_d = addr_err ? ST_ERR1 : ST_ADDR_OK;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // State, address-phase and START pulse registers
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            waddr_q <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            write_q <= write_d;
            size_q  <= size_d;
            start_q <= start_d;
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .clr_i   (fifo_clr),
        .wdata_i (HWDATA),
        .rdata_o (M_DATA),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign HREADY  = hready_c;
    assign HRESP   = hresp_c;
    assign HRDATA  = hrdata_c;
    assign START   = start_q;
    assign M_VALID = !fifo_empty;

endmodule

// File: tb/tb_ahb_stream_slave.sv
// Directed bench for ahb_stream_slave: register access, FIFO fill/stall/drain,
// streaming during a burst, reset mid-stall and unmapped-address handling.
module tb_ahb_stream_slave;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [7:0]  HADDR = '0;
    logic [2:0]  HBURST = '0;
    logic [2:0]  HSIZE = 3'b010;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [31:0] HWDATA = '0;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        START;
    logic [31:0] M_DATA;
    logic        M_VALID;
    logic        M_READY = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    ahb_stream_slave #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (32),
        .DATA_WADDR (16)
    ) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .HADDR   (HADDR),
        .HBURST  (HBURST),
        .HSIZE   (HSIZE),
        .HTRANS  (HTRANS),
        .HWRITE  (HWRITE),
        .HWDATA  (HWDATA),
        .HREADY  (HREADY),
        .HRDATA  (HRDATA),
        .HRESP   (HRESP),
        .START   (START),
        .M_DATA  (M_DATA),
        .M_VALID (M_VALID),
        .M_READY (M_READY)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bus drivers ----------------
    task automatic wait_ready();
        int n = 0;
        while (HREADY !== 1'b1 && n < 64) begin
            @(posedge ACLK); #1;
            n++;
        end
        if (HREADY !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL hready_timeout: got %b want 1", HREADY);
        end
    endtask

    task automatic ahb_write(input logic [7:0] a, input logic [31:0] d, output logic resp);
        @(posedge ACLK); #1;
        HADDR = a; HWRITE = 1'b1; HSIZE = 3'b010; HTRANS = 2'b10;
        @(posedge ACLK); #1;
        HTRANS = 2'b00; HWDATA = d;
        wait_ready();
        resp = HRESP;
        @(posedge ACLK); #1;
    endtask

    task automatic ahb_read(input logic [7:0] a, output logic [31:0] d, output logic resp);
        @(posedge ACLK); #1;
        HADDR = a; HWRITE = 1'b0; HSIZE = 3'b010; HTRANS = 2'b10;
        @(posedge ACLK); #1;
        HTRANS = 2'b00;
        wait_ready();
        d = HRDATA;
        resp = HRESP;
        @(posedge ACLK); #1;
    endtask

    // Fixed-address pipelined write burst; counts data-phase wait states
    task automatic ahb_burst(input logic [7:0] a, input int n, input logic [31:0] base,
                             output int waits);
        waits = 0;
        @(posedge ACLK); #1;
        HADDR = a; HWRITE = 1'b1; HSIZE = 3'b010; HTRANS = 2'b10;
        for (int i = 0; i < n; i++) begin
            int c = 0;
            @(posedge ACLK); #1;
            HWDATA = base + 32'(i);
            HTRANS = (i < n - 1) ? 2'b11 : 2'b00;
            while (HREADY !== 1'b1 && c < 64) begin
                @(posedge ACLK); #1;
                waits++; c++;
            end
            if (HREADY !== 1'b1) begin
                n_cmp++; n_bad++;
                $display("FAIL burst_timeout: beat %0d got HREADY %b want 1", i, HREADY);
            end
        end
        @(posedge ACLK); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        n_cmp++; if (HREADY !== 1'b1) begin n_bad++; $display("FAIL reset_hready: got %b want 1", HREADY); end
        n_cmp++; if (HRDATA !== 32'h0) begin n_bad++; $display("FAIL reset_hrdata: got %h want 0", HRDATA); end
        n_cmp++; if (HRESP !== 1'b0) begin n_bad++; $display("FAIL reset_hresp: got %b want 0", HRESP); end
        n_cmp++; if (START !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", START); end
        n_cmp++; if (M_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_mvalid: got %b want 0", M_VALID); end
        ARESET = 1'b0;
        @(posedge ACLK); #1;
    endtask

    task automatic test_ctrl_start();
        logic        r;
        logic [31:0] d;
        ahb_write(8'h40, 32'h0000_0011, r);
        ahb_write(8'h40, 32'h0000_0022, r);
        n_cmp++; if (M_VALID !== 1'b1) begin n_bad++; $display("FAIL prefill_mvalid: got %b want 1", M_VALID); end
        ahb_write(8'h00, 32'h0000_0003, r);
        n_cmp++; if (r !== 1'b0) begin n_bad++; $display("FAIL ctrl_resp: got %b want 0", r); end
        n_cmp++; if (START !== 1'b1) begin n_bad++; $display("FAIL start_pulse: got %b want 1", START); end
        n_cmp++; if (M_VALID !== 1'b0) begin n_bad++; $display("FAIL clr_mvalid: got %b want 0", M_VALID); end
        @(posedge ACLK); #1;
        n_cmp++; if (START !== 1'b0) begin n_bad++; $display("FAIL start_width: got %b want 0", START); end
        ahb_read(8'h04, d, r);
        n_cmp++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL status_empty: got %h want 00000001", d); end
        ahb_read(8'h00, d, r);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL ctrl_read: got %h want 0", d); end
    endtask

    task automatic test_burst_fill();
        int          w;
        logic        r;
        logic [31:0] d;
        M_READY = 1'b0;
        ahb_burst(8'h40, 32, 32'hA000_0000, w);
        n_cmp++; if (w !== 0) begin n_bad++; $display("FAIL fill_waits: got %0d want 0", w); end
        ahb_read(8'h04, d, r);
        n_cmp++; if (d !== 32'h0000_2002) begin n_bad++; $display("FAIL status_full: got %h want 00002002", d); end
        n_cmp++; if (M_DATA !== 32'hA000_0000) begin n_bad++; $display("FAIL fill_head: got %h want a0000000", M_DATA); end
        n_cmp++; if (M_VALID !== 1'b1) begin n_bad++; $display("FAIL fill_mvalid: got %b want 1", M_VALID); end
    endtask

    task automatic test_full_stall();
        logic        r;
        logic [31:0] d;
        logic [31:0] exp;
        @(posedge ACLK); #1;
        HADDR = 8'h40; HWRITE = 1'b1; HSIZE = 3'b010; HTRANS = 2'b10;
        @(posedge ACLK); #1;
        HTRANS = 2'b00; HWDATA = 32'hA000_0033;
        n_cmp++; if (HREADY !== 1'b0) begin n_bad++; $display("FAIL stall_first: got %b want 0", HREADY); end
        @(posedge ACLK); #1;
        n_cmp++; if (HREADY !== 1'b0) begin n_bad++; $display("FAIL stall_hold: got %b want 0", HREADY); end
        M_READY = 1'b1;
        @(posedge ACLK); #1;
        M_READY = 1'b0;
        n_cmp++; if (HREADY !== 1'b1) begin n_bad++; $display("FAIL stall_release: got %b want 1", HREADY); end
        n_cmp++; if (M_DATA !== 32'hA000_0001) begin n_bad++; $display("FAIL stall_pop_head: got %h want a0000001", M_DATA); end
        @(posedge ACLK); #1;
        ahb_read(8'h04, d, r);
        n_cmp++; if (d !== 32'h0000_2002) begin n_bad++; $display("FAIL stall_status: got %h want 00002002", d); end
        M_READY = 1'b1;
        for (int k = 0; k < 32; k++) begin
            exp = (k < 31) ? 32'hA000_0001 + 32'(k) : 32'hA000_0033;
            n_cmp++; if (M_DATA !== exp) begin n_bad++; $display("FAIL drain_%0d: got %h want %h", k, M_DATA, exp); end
            @(posedge ACLK); #1;
        end
        M_READY = 1'b0;
        n_cmp++; if (M_VALID !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b want 0", M_VALID); end
    endtask

    task automatic test_stream_through();
        int          w;
        logic        r;
        logic [31:0] d;
        logic [31:0] got[$];
        M_READY = 1'b1;
        fork
            ahb_burst(8'h40, 32, 32'hB000_0000, w);
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge ACLK);
                    if (M_VALID && M_READY) got.push_back(M_DATA);
                end
            end
        join
        n_cmp++; if (w !== 0) begin n_bad++; $display("FAIL stream_waits: got %0d want 0", w); end
        n_cmp++; if (got.size() !== 32) begin n_bad++; $display("FAIL stream_count: got %0d want 32", got.size()); end
        for (int i = 0; i < got.size() && i < 32; i++) begin
            n_cmp++;
            if (got[i] !== 32'hB000_0000 + 32'(i)) begin
                n_bad++; $display("FAIL stream_order_%0d: got %h want %h", i, got[i], 32'hB000_0000 + 32'(i));
            end
        end
        ahb_read(8'h04, d, r);
        n_cmp++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL stream_status: got %h want 00000001", d); end
        M_READY = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        int          w;
        logic        r;
        logic [31:0] d;
        ahb_burst(8'h40, 32, 32'hC000_0000, w);
        @(posedge ACLK); #1;
        HADDR = 8'h40; HWRITE = 1'b1; HSIZE = 3'b010; HTRANS = 2'b10;
        @(posedge ACLK); #1;
        HTRANS = 2'b00; HWDATA = 32'hC000_00FF;
        n_cmp++; if (HREADY !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", HREADY); end
        @(posedge ACLK); #1;
        ARESET = 1'b1;
        #1;
        n_cmp++; if (HREADY !== 1'b1) begin n_bad++; $display("FAIL rst_async_hready: got %b want 1", HREADY); end
        n_cmp++; if (M_VALID !== 1'b0) begin n_bad++; $display("FAIL rst_async_mvalid: got %b want 0", M_VALID); end
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        ahb_read(8'h04, d, r);
        n_cmp++; if (r !== 1'b0) begin n_bad++; $display("FAIL rst_next_resp: got %b want 0", r); end
        n_cmp++; if (d !== 32'h0000_0001) begin n_bad++; $display("FAIL rst_next_status: got %h want 00000001", d); end
        ahb_write(8'h40, 32'h0000_0055, r);
        n_cmp++; if (r !== 1'b0) begin n_bad++; $display("FAIL rst_push_resp: got %b want 0", r); end
        n_cmp++; if (M_DATA !== 32'h0000_0055) begin n_bad++; $display("FAIL rst_push_data: got %h want 00000055", M_DATA); end
        ahb_read(8'h04, d, r);
        n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL rst_push_status: got %h want 00000100", d); end
    endtask

    task automatic test_unmapped();
        logic        r;
        logic [31:0] d;
        @(posedge ACLK); #1;
        HADDR = 8'h80; HWRITE = 1'b1; HSIZE = 3'b010; HTRANS = 2'b10;
        @(posedge ACLK); #1;
        HTRANS = 2'b00; HWDATA = 32'hDEAD_BEEF;
`ifdef AHB_SLV_ERR_EN
        n_cmp++; if (HREADY !== 1'b0) begin n_bad++; $display("FAIL err1_hready: got %b want 0", HREADY); end
        n_cmp++; if (HRESP !== 1'b1) begin n_bad++; $display("FAIL err1_hresp: got %b want 1", HRESP); end
        @(posedge ACLK); #1;
        n_cmp++; if (HREADY !== 1'b1) begin n_bad++; $display("FAIL err2_hready: got %b want 1", HREADY); end
        n_cmp++; if (HRESP !== 1'b1) begin n_bad++; $display("FAIL err2_hresp: got %b want 1", HRESP); end
`else
        n_cmp++; if (HREADY !== 1'b1) begin n_bad++; $display("FAIL unmapped_hready: got %b want 1", HREADY); end
        n_cmp++; if (HRESP !== 1'b0) begin n_bad++; $display("FAIL unmapped_hresp: got %b want 0", HRESP); end
`endif
        @(posedge ACLK); #1;
        ahb_read(8'h04, d, r);
        n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL unmapped_status: got %h want 00000100", d); end
        n_cmp++; if (M_DATA !== 32'h0000_0055) begin n_bad++; $display("FAIL unmapped_head: got %h want 00000055", M_DATA); end
    endtask

    initial begin
        test_reset();
        test_ctrl_start();
        test_burst_fill();
        test_full_stall();
        test_stream_through();
        test_reset_mid_stall();
        test_unmapped();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
